// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for transmitter and receiver
package uart_pkg;

  localparam int   UART_DATA_W = 8;
  localparam logic IDLE_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Even parity of one data byte
  function automatic logic even_parity(input logic [UART_DATA_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period divider, tick on the last clock of each period
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running divider; clr holds it at zero so a bit period starts cleanly
  always_ff @(posedge Clk) begin
    if (Reset || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_fifo_tx.sv
// rtl/uart_fifo_tx.sv - FIFO-draining UART transmitter, 8N1 (8E1 with UART_TX_PARITY_EN)
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_RD_LAT  = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Tx_Enable,
  input  logic       Fifo_Empty,
  input  logic [7:0] Fifo_Data,
  output logic       Read,
  output logic       Tx,
  output logic       Busy,
  output logic       Tx_Done
);

  localparam logic [1:0] FETCH_LAST = 2'(FIFO_RD_LAT);
  localparam logic       STOP_LAST  = 1'(STOP_BITS - 1);

  tx_state_t state;
  tx_state_t next_state;

  logic                   tick;
  logic                   clr;
  logic [UART_DATA_W-1:0] shift;
  logic [2:0]             bit_cnt;
  logic [1:0]             fetch_cnt;
  logic                   stop_cnt;
  logic                   capture;
  logic                   start_read;
  logic                   stop_end;
  logic                   tx_level;
  logic                   read_q;
  logic                   tx_q;
  logic                   busy_q;
  logic                   done_q;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q;
`endif

  // The bit-period counter only runs once a frame is on the line
  assign clr = (state == IDLE) || (state == FETCH);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .Clk  (Clk),
    .Reset(Reset),
    .clr  (clr),
    .tick (tick)
  );

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the line level each state calls for
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    start_read = 1'b0;
    stop_end   = 1'b0;
    tx_level   = IDLE_LEVEL;
    case (state)
      IDLE: begin
        if (Tx_Enable && !Fifo_Empty) begin
          start_read = 1'b1;
          next_state = FETCH;
        end
      end
      FETCH: begin
        if (fetch_cnt == FETCH_LAST) begin
          capture    = 1'b1;
          next_state = START;
        end
      end
      START: begin
        tx_level = 1'b0;
        if (tick) begin
          next_state = DATA;
        end
      end
      DATA: begin
        tx_level = shift[0];
        if (tick && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end
      end
      PARITY: begin
`ifdef UART_TX_PARITY_EN
        tx_level = parity_q;
`endif
        if (tick) begin
          next_state = STOP;
        end
      end
      STOP: begin
        if (tick && stop_cnt == STOP_LAST) begin
          stop_end   = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Shift register and the fetch/bit/stop counters
  always_ff @(posedge Clk) begin
    if (Reset) begin
      shift     <= '0;
      bit_cnt   <= '0;
      fetch_cnt <= '0;
      stop_cnt  <= 1'b0;
    end else begin
      if (state == FETCH && !capture) begin
        fetch_cnt <= fetch_cnt + 1'b1;
      end else begin
        fetch_cnt <= '0;
      end

      if (capture) begin
        shift <= Fifo_Data;
      end else if (state == DATA && tick) begin
        shift <= {1'b0, shift[UART_DATA_W-1:1]};
      end

      if (state == DATA) begin
        if (tick) begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else begin
        bit_cnt <= '0;
      end

      if (state == STOP) begin
        if (tick) begin
          stop_cnt <= (stop_cnt == STOP_LAST) ? 1'b0 : stop_cnt + 1'b1;
        end
      end else begin
        stop_cnt <= 1'b0;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is taken from the byte as it leaves the FIFO
  always_ff @(posedge Clk) begin
    if (Reset) begin
      parity_q <= 1'b0;
    end else if (capture) begin
      parity_q <= even_parity(Fifo_Data);
    end
  end
`endif

  // Registered outputs: Tx, Tx_Done and Busy trail the state by one clock
  always_ff @(posedge Clk) begin
    if (Reset) begin
      read_q <= 1'b0;
      tx_q   <= IDLE_LEVEL;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      read_q <= start_read;
      tx_q   <= tx_level;
      busy_q <= (next_state != IDLE) || (state != IDLE);
      done_q <= stop_end;
    end
  end

  assign Read    = read_q;
  assign Tx      = tx_q;
  assign Busy    = busy_q;
  assign Tx_Done = done_q;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb/tb_uart_fifo_tx.sv - scoreboard bench for uart_fifo_tx (honours UART_TX_PARITY_EN)
module tb_uart_fifo_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = (10 + PAR) * CPB;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Tx_Enable = 1'b0;
  logic       Fifo_Empty;
  logic [7:0] Fifo_Data = 8'h00;
  logic       Read;
  logic       Tx;
  logic       Busy;
  logic       Tx_Done;

  uart_fifo_tx #(
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (1),
    .FIFO_RD_LAT (1)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Tx_Enable (Tx_Enable),
    .Fifo_Empty(Fifo_Empty),
    .Fifo_Data (Fifo_Data),
    .Read      (Read),
    .Tx        (Tx),
    .Busy      (Busy),
    .Tx_Done   (Tx_Done)
  );

  always #5 Clk = ~Clk;

  // FIFO model with one cycle of read latency
  logic [7:0] mem [0:15];
  int wr_cnt = 0;
  int rd_cnt = 0;
  assign Fifo_Empty = (rd_cnt == wr_cnt);

  always @(posedge Clk) begin
    if (Read && rd_cnt < wr_cnt) begin
      Fifo_Data <= mem[rd_cnt];
      rd_cnt    <= rd_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_pass = 0;

  // Scoreboard entries: {hand-computed even parity, byte}
  logic [8:0] exp_q[$];

  int   read_cnt = 0;
  int   done_cnt = 0;
  int   frames = 0;
  int   high_run = 0;
  int   last_gap = 0;
  int   mon_cyc = 0;
  int   frame_bad = 0;
  bit   mon_active = 0;
  bit   prev_read = 0;
  logic [8:0] cur = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
  endtask

  function automatic logic exp_level(input logic [8:0] e, input int bit_i);
    if (bit_i == 0) return 1'b0;
    if (bit_i <= 8) return e[bit_i-1];
    if (PAR == 1 && bit_i == 9) return e[8];
    return 1'b1;
  endfunction

  task automatic push(input logic [7:0] b, input logic par);
    mem[wr_cnt] = b;
    exp_q.push_back({par, b});
    wr_cnt = wr_cnt + 1;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames < target && n < 3000) begin
      @(negedge Clk);
      n++;
    end
    check("wait_frames", frames, target);
  endtask

  // Monitor: decodes the line every clock and compares each frame against the scoreboard
  task automatic monitor();
    int  bit_i;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        mon_active = 0;
        high_run   = 0;
        prev_read  = 0;
      end else begin
        if (Read) begin
          read_cnt++;
          check("read_while_empty", Fifo_Empty, 0);
          check("read_width", prev_read, 0);
        end
        prev_read = Read;
        if (Tx_Done) done_cnt++;

        if (!mon_active && Tx == 1'b0) begin
          check("frame_expected", exp_q.size() != 0, 1);
          cur = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h0;
          last_gap   = high_run;
          mon_active = 1;
          mon_cyc    = 0;
          frame_bad  = 0;
        end else if (!mon_active) begin
          high_run++;
        end

        if (mon_active) begin
          bit_i = mon_cyc / CPB;
          if (Tx !== exp_level(cur, bit_i)) frame_bad++;
          if (Tx_Done !== (mon_cyc == FRAME - 1)) frame_bad++;
          if (Busy !== 1'b1) frame_bad++;
          if (mon_cyc == FRAME - 1) begin
            $display("frame byte 0x%02h: %0d bad cycles", cur[7:0], frame_bad);
            check("frame_cycles", frame_bad, 0);
            frames++;
            mon_active = 0;
            high_run   = 0;
          end
          mon_cyc++;
        end
      end
    end
  endtask

  initial begin
    int rd0;
    int d0;
    int n;
    bit tx_low;

    fork
      monitor();
    join_none

    // 1: reset held with data waiting
    Tx_Enable = 1'b1;
    push(8'h5A, 1'b0);
    repeat (3) begin
      @(negedge Clk);
      check("reset_outputs", {Tx, Read, Busy, Tx_Done}, 4'b1000);
    end
    Reset = 1'b0;

    // 2: single byte 0x5A
    wait_frames(1);
    repeat (3) @(negedge Clk);
    check("busy_after_frame", Busy, 0);
    check("reads_one", read_cnt, 1);
    check("done_one", done_cnt, 1);

    // 3: back-to-back 0xA5, 0xDB
    push(8'hA5, 1'b0);
    push(8'hDB, 1'b0);
    wait_frames(3);
    check("gap_cycles", last_gap, 3);
    check("reads_three", read_cnt, 3);

    // 4: empty FIFO, then disabled with data, then enable
    rd0 = read_cnt;
    tx_low = 0;
    repeat (100) begin
      @(negedge Clk);
      if (Tx !== 1'b1) tx_low = 1;
    end
    check("no_read_empty", read_cnt, rd0);
    check("tx_idle_empty", tx_low, 0);
    Tx_Enable = 1'b0;
    push(8'h3C, 1'b0);
    repeat (100) begin
      @(negedge Clk);
      if (Tx !== 1'b1) tx_low = 1;
    end
    check("no_read_disabled", read_cnt, rd0);
    check("tx_idle_disabled", tx_low, 0);
    Tx_Enable = 1'b1;
    @(negedge Clk);
    check("read_next_cycle", Read, 1);
    wait_frames(4);

    // 5: reset during data bit 3 of 0xF0
    push(8'hF0, 1'b0);
    n = 0;
    while (Tx !== 1'b0 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check("start_seen", Tx, 0);
    repeat (17) @(negedge Clk);
    Reset = 1'b1;
    d0 = done_cnt;
    @(negedge Clk);
    check("abort_tx_busy", {Tx, Busy}, 2'b10);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (30) @(negedge Clk);
    check("abort_no_done", done_cnt, d0);
    check("abort_tx_idle", Tx, 1);
    check("abort_frames", frames, 4);
    push(8'h81, 1'b0);
    wait_frames(5);

    // 6: parity bytes (plain 8N1 frames when parity is not built in)
    push(8'h07, 1'b1);
    push(8'h5A, 1'b0);
    wait_frames(7);
    repeat (5) @(negedge Clk);

    check("scoreboard_empty", exp_q.size(), 0);
    check("total_reads", read_cnt, 8);
    check("total_done", done_cnt, 7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
